// File: rtl/store_narrow.sv
// store_narrow: multi-cycle sub-word store unit for the MEM stage.
// Byte/halfword stores read-modify-write one big-endian word.
module store_narrow (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        chk,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [29:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic        hw_q, hw_d;
  logic [15:0] wd_q, wd_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] merged;
  logic        bad;

  // Narrowing must round-trip through sign extension when chk is set.
  always_comb begin
    bad = 1'b0;
    if (size == 2'b11)
      bad = 1'b1;
    if (size == 2'b01 && addr[0])
      bad = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)
      bad = 1'b1;
    if (chk && size == 2'b00 && wdata[31:8] != {24{wdata[7]}})
      bad = 1'b1;
    if (chk && size == 2'b01 && wdata[31:16] != {16{wdata[15]}})
      bad = 1'b1;
  end

  always_comb begin
    merged = mem_rdata;
    if (hw_q) begin
      if (lane_q[1])
        merged[15:0] = wd_q;
      else
        merged[31:16] = wd_q;
    end else begin
      unique case (lane_q)
        2'd0: merged[31:24] = wd_q[7:0];
        2'd1: merged[23:16] = wd_q[7:0];
        2'd2: merged[15:8]  = wd_q[7:0];
        2'd3: merged[7:0]   = wd_q[7:0];
        default: merged = mem_rdata;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hw_d    = hw_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    wdat_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr[31:2];
          lane_d = addr[1:0];
          hw_d   = size[0];
          wd_d   = wdata[15:0];
          if (bad) begin
            state_d = S_FAIL;
          end else if (size == 2'b10) begin
            state_d = S_WRITE;
            wdat_d  = wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        state_d = S_WRITE;
        wdat_d  = merged;
      end
      S_WRITE: state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_WRITE) || (state_d == S_FAIL);
    err_d  = (state_d == S_FAIL);
    rd_d   = (state_d == S_READ);
    wr_d   = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      hw_q    <= 1'b0;
      wd_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hw_q    <= hw_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign mem_wdata = wdat_q;

endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed plus random stores against a byte-level
// reference model of a small big-endian word memory.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        chk;
  logic        busy;
  logic        done;
  logic        err;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] dut_mem [16];
  logic [31:0] ref_mem [16];

  store_narrow dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr),
    .wdata(wdata), .size(size), .chk(chk), .busy(busy),
    .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory the DUT talks to.
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= dut_mem[mem_addr[3:0]];
    if (mem_wr_en)
      dut_mem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a,
                                  input logic [31:0] wd,
                                  input logic [1:0] sz,
                                  input logic c);
    int v;
    v = $signed(wd);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if (c && sz == 2'd0 && (v < -128 || v > 127)) return 1'b1;
    if (c && sz == 2'd1 && (v < -32768 || v > 32767)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] w,
                                            input logic [31:0] a,
                                            input logic [31:0] wd,
                                            input logic [1:0] sz);
    logic [7:0] b [4];
    int k;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    k = a % 4;
    case (sz)
      2'd0: b[k] = wd[7:0];
      2'd1: begin
        b[k]   = wd[15:8];
        b[k+1] = wd[7:0];
      end
      default: for (int i = 0; i < 4; i++) b[i] = wd[31-8*i -: 8];
    endcase
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic do_store(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [1:0] sz,
                          input logic c);
    logic        exp_bad;
    int          exp_lat;
    int          idx;
    logic [31:0] exp_w;
    int          rd_n = 0, wr_n = 0, dn_n = 0, bz_n = 0;
    int          dcyc = 0;
    logic        e = 1'b0;
    logic [31:0] wv = '0;
    logic        addr_ok = 1'b1;
    exp_bad = is_bad(a, wd, sz, c);
    exp_lat = (exp_bad || sz == 2'd2) ? 1 : 3;
    idx = int'(a[5:2]);
    exp_w = merge_ref(ref_mem[idx], a, wd, sz);
    @(negedge clk);
    addr = a; wdata = wd; size = sz; chk = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (mem_rd_en) rd_n++;
      if (mem_wr_en) wr_n++;
      if (busy) bz_n++;
      if (busy && mem_addr !== a[31:2]) addr_ok = 1'b0;
      if (!mem_wr_en && mem_wdata !== 32'h0) addr_ok = 1'b0;
      if (done) begin
        dn_n++;
        if (dcyc == 0) begin
          dcyc = cyc;
          e = err;
          wv = mem_wdata;
        end
      end
    end
    check({tag, ".done_cyc"}, dcyc, exp_lat);
    check({tag, ".done_cnt"}, dn_n, 1);
    check({tag, ".err"}, {31'b0, e}, {31'b0, exp_bad});
    check({tag, ".busy_cyc"}, bz_n, exp_lat);
    check({tag, ".rd_cnt"}, rd_n, (exp_bad || sz == 2'd2) ? 0 : 1);
    check({tag, ".wr_cnt"}, wr_n, exp_bad ? 0 : 1);
    check({tag, ".addr_wd_hold"}, {31'b0, addr_ok}, 32'd1);
    if (!exp_bad) begin
      check({tag, ".wdata"}, wv, exp_w);
      ref_mem[idx] = exp_w;
    end
    check({tag, ".mem"}, dut_mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] r, a, wd;
    logic [1:0]  sz;
    logic        c;
    int          pick;
    logic [4:0]  dn_bits, bz_bits;
    int          wr_seen;
    rst = 1'b1; start = 1'b0; addr = '0; wdata = '0;
    size = '0; chk = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      dut_mem[i] = r;
      ref_mem[i] = r;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'b0, busy}, 0);
    check("rst.done", {31'b0, done}, 0);
    check("rst.err", {31'b0, err}, 0);
    check("rst.rd", {31'b0, mem_rd_en}, 0);
    check("rst.wr", {31'b0, mem_wr_en}, 0);
    check("rst.addr", {2'b0, mem_addr}, 0);
    check("rst.wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    do_store("t1_word", 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
    dut_mem[0] = 32'h11223344;
    ref_mem[0] = 32'h11223344;
    do_store("t2_byte", 32'h102, 32'h000000AB, 2'd0, 1'b0);
    check("t2_byte.val", ref_mem[0], 32'h1122AB44);
    dut_mem[1] = 32'hAAAAAAAA;
    ref_mem[1] = 32'hAAAAAAAA;
    do_store("t3_half", 32'h006, 32'hFFFF8001, 2'd1, 1'b1);
    check("t3_half.val", ref_mem[1], 32'hAAAA8001);
    do_store("t4_range", 32'h000, 32'h00000080, 2'd0, 1'b1);
    do_store("t4_hmis", 32'h101, 32'h00001234, 2'd1, 1'b0);
    do_store("t4_wmis", 32'h102, 32'h12345678, 2'd2, 1'b0);
    do_store("t4_size", 32'h100, 32'h12345678, 2'd3, 1'b0);
    do_store("t4_hrange", 32'h004, 32'h00008000, 2'd1, 1'b1);
    do_store("t4_bok", 32'h003, 32'hFFFFFF80, 2'd0, 1'b1);

    // Reset asserted asynchronously during CAPTURE of a byte store.
    @(negedge clk);
    addr = 32'h109; wdata = 32'h5A; size = 2'd0; chk = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5.busy", {31'b0, busy}, 0);
    check("t5.done", {31'b0, done}, 0);
    check("t5.rd", {31'b0, mem_rd_en}, 0);
    check("t5.addr", {2'b0, mem_addr}, 0);
    check("t5.wdata", mem_wdata, 0);
    wr_seen = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (mem_wr_en) wr_seen++;
    end
    check("t5.no_wr", wr_seen, 0);
    check("t5.mem", dut_mem[2], ref_mem[2]);
    do_store("t5_after", 32'h108, 32'hCAFEF00D, 2'd2, 1'b0);

    // start held high through three word stores.
    @(negedge clk);
    addr = 32'h200; wdata = 32'h0BADC0DE; size = 2'd2; chk = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
      dn_bits[cyc-1] = done;
      bz_bits[cyc-1] = busy;
    end
    start = 1'b0;
    ref_mem[0] = 32'h0BADC0DE;
    check("t6.done", {27'b0, dn_bits}, 32'b10101);
    check("t6.busy", {27'b0, bz_bits}, 32'b10101);
    repeat (2) @(posedge clk);
    #1 check("t6.mem", dut_mem[0], ref_mem[0]);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      r = $urandom;
      pick = $urandom_range(0, 2);
      if (pick == 0) wd = {{24{r[7]}}, r[7:0]};
      else if (pick == 1) wd = {{16{r[15]}}, r[15:0]};
      else wd = r;
      sz = 2'($urandom_range(0, 3));
      c = 1'($urandom_range(0, 1));
      do_store("rand", a, wd, sz, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Multi-cycle sub-word store unit for the MEM stage of the pipelined CPU. It narrows a 32-bit register value to a byte, halfword or word and writes it into the word-wide data memory. Byte and halfword stores use a read-modify-write sequence so the other lanes of the word are preserved. An optional range check rejects values that would not sign-extend back to the original 32-bit value, making it the inverse of the immediate sign-extension path.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- addr  in  32  byte address of the store
- wdata  in  32  register value to store
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- chk  in  1  1 = enable the signed-range check on narrowing
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done
- mem_addr  out  30  word address (addr[31:2]) sent to data memory
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  memory write strobe
- mem_wdata  out  32  merged write word

## Operation
- **Capture:** in IDLE, `start` = 1 registers addr, wdata, size and chk.
- **FSM states:** IDLE, READ, CAPTURE, WRITE, FAIL.
- **Error checks.** These are evaluated on the captured values. If any holds, the next state is FAIL.
  - size = 11.
  - size = 01 with addr[0] = 1.
  - size = 10 with addr[1:0] ≠ 00.
  - chk = 1, size = 00, and wdata[31:8] is not all copies of wdata[7].
  - chk = 1, size = 01, and wdata[31:16] is not all copies of wdata[15].
- **Transitions without error:**
  - size = 10: IDLE → WRITE.
  - size = 00 or 01: IDLE → READ → CAPTURE → WRITE.
- **State actions:**
  - READ drives mem_rd_en = 1.
  - CAPTURE registers mem_rdata into the merge register.
  - WRITE drives mem_wr_en = 1, done = 1, and returns to IDLE.
  - FAIL drives done = 1 and err = 1, makes no memory access, and returns to IDLE.
- **Lane mapping (big-endian):**
  - addr[1:0] = 00 → bits 31:24; 01 → 23:16; 10 → 15:8; 11 → 7:0.
  - A halfword at addr[1] = 0 occupies bits 31:16; at addr[1] = 1 it occupies bits 15:0.
- **Merge:**
  - Byte stores write wdata[7:0] into the selected lane.
  - Halfword stores write wdata[15:0] into the selected lane.
  - All other bits come from the captured read word.
  - A word store sets mem_wdata = wdata.
- **Address:** mem_addr is driven from the captured addr[31:2] and is held constant from the cycle after start until the return to IDLE.
- **Busy:** busy = 1 in every state except IDLE.
- **Back-to-back requests:** a start coincident with done is ignored, because the FSM is not yet in IDLE. The next request is accepted one cycle later.

## Timing
- **Latency**, with start sampled at edge 0:
  - Word store: mem_wr_en and done are high in cycle 1.
  - Byte or halfword store: mem_rd_en in cycle 1, capture in cycle 2, mem_wr_en and done in cycle 3.
  - Error: done and err are high in cycle 1.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs. mem_wdata is valid whenever mem_wr_en = 1 and is 0 otherwise.
- **Reset values:**
  - State = IDLE.
  - busy, done, err, mem_rd_en and mem_wr_en = 0.
  - mem_addr = 0 and mem_wdata = 0.
- **Reset mid-operation:** asserting rst in any state returns to IDLE immediately, asynchronously. No write strobe is issued afterwards, and the captured operands are discarded.
- **Memory assumption:** mem_rdata must be stable for the CAPTURE cycle. The memory has exactly one cycle of read latency.

## Test plan
1. Word store: addr = 0x100, wdata = 0xDEADBEEF, size = 10 → mem_wr_en in cycle 1, mem_addr = 0x40, mem_wdata = 0xDEADBEEF, done = 1, err = 0.
2. Byte store: addr = 0x102, wdata = 0x000000AB, size = 00, chk = 0, mem_rdata = 0x11223344 → cycle 3 mem_wdata = 0x1122AB44, done = 1.
3. Halfword store: addr = 0x006, wdata = 0xFFFF8001, size = 01, chk = 1, mem_rdata = 0xAAAAAAAA → in range, so cycle 3 mem_wdata = 0xAAAA8001.
4. Range and alignment errors: each of the following gives done = err = 1 in cycle 1 with mem_rd_en = mem_wr_en = 0 throughout.
   - wdata = 0x00000080, size = 00, chk = 1.
   - addr = 0x101, size = 01.
   - addr = 0x102, size = 10.
   - size = 11.
5. Reset mid-operation: assert rst during CAPTURE of a byte store → no mem_wr_en is ever issued, all outputs are 0, and a subsequent word store completes normally in cycle 1.
6. Back-to-back requests: start held high continuously with word stores → done in cycles 1, 3, 5. The start at each done cycle is ignored, and busy is low exactly in cycles 2 and 4.
